// File: rtl/aes_out_pkg.sv
// rtl/aes_out_pkg.sv - shared constants and types for the AES output collector
package aes_out_pkg;

    localparam int AES_BLK_W        = 128;
    localparam int AES_CORE_LATENCY = 21;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

endpackage

// File: rtl/aes_out_fifo.sv
// rtl/aes_out_fifo.sv - first-word-fall-through result FIFO with occupancy count
module aes_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 132,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             pop;
    logic             push;

    // A pop frees the head slot on the same edge, so a write into a full FIFO is
    // only taken when it is paired with a pop; otherwise it would clobber the head.
    assign pop   = rd_en && (count_q != '0);
    assign push  = wr_en && ((count_q != FULL_CNT) || pop);
    assign count = count_q;

    // Head entry is shown directly; an empty FIFO presents zeros.
    assign rd_data = (count_q != '0) ? mem[rd_ptr] : '0;

    // Storage array needs no reset: its contents are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; full/empty come from the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && !pop && (count_q == FULL_CNT)))
        else $error("aes_out_fifo: capture into full FIFO without pop");
`endif

endmodule

// File: rtl/aes_out_collector.sv
// rtl/aes_out_collector.sv - tracks AES core issues, captures ciphertext, credit-gated FWFT output (optional AES_OUT_ZERO_CHK_EN)
module aes_out_collector
    import aes_out_pkg::*;
#(
    parameter int LATENCY = AES_CORE_LATENCY,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [TAG_W-1:0]     issue_tag,
    input  logic [AES_BLK_W-1:0] core_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [AES_BLK_W-1:0] m_data,
    output logic [TAG_W-1:0]     m_tag,
    output logic [CNT_W-1:0]     inflight,
    output logic [CNT_W-1:0]     fifo_cnt
`ifdef AES_OUT_ZERO_CHK_EN
    ,
    output logic                 zero_flag
`endif
);

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic               issue_accept;
    logic               capture;
    logic               pop;
    logic [CNT_W:0]     credit_sum;
    logic [LATENCY-1:0] dl_valid;
    logic [TAG_W-1:0]   dl_tag [LATENCY];

    // Every slot is owned either by a buffered result or a block still in the core.
    assign credit_sum   = {1'b0, fifo_cnt} + {1'b0, inflight};
    assign issue_ready  = credit_sum < DEPTH_C;
    assign issue_accept = issue_valid && issue_ready;
    assign capture      = dl_valid[LATENCY-1];
    assign m_valid      = (fifo_cnt != '0);
    assign pop          = m_valid && m_ready;

    // Valid/tag delay line mirrors the non-stallable core pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_tag[i] <= '0;
            end
        end else begin
            dl_valid  <= {dl_valid[LATENCY-2:0], issue_accept};
            dl_tag[0] <= issue_accept ? issue_tag : '0;
            for (int i = 1; i < LATENCY; i++) begin
                dl_tag[i] <= dl_tag[i-1];
            end
        end
    end

    // Blocks in flight: up on accept, down on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue_accept, capture})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    aes_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TAG_W + AES_BLK_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data ({dl_tag[LATENCY-1], core_out}),
        .rd_en   (pop),
        .rd_data ({m_tag, m_data}),
        .count   (fifo_cnt)
    );

`ifdef AES_OUT_ZERO_CHK_EN
    // Sticky flag for an all-zero ciphertext, a sign of a blanked core output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_flag <= 1'b0;
        end else if (capture && (core_out == '0)) begin
            zero_flag <= 1'b1;
        end
    end
`endif

endmodule
